// File: rtl/tile_map_ctl.sv
// Tile-map overlay for the VGA pixel pipeline.
// Renders walls, coins and power-ups from a flat map vector with a fixed
// 2-cycle video latency. A once-per-frame scanner walks all tiles to produce
// per-direction hero blocking and to collect items into a saturating score.
module tile_map_ctl #(
   parameter int COLS     = 15,
   parameter int ROWS     = 10,
   parameter int TILE     = 60,
   parameter int X0       = 61,
   parameter int Y0       = 108,
   parameter int TYPE_W   = 4,
   parameter int MARGIN   = 15,
   parameter int COIN_PTS = 100,
   parameter int PWR_PTS  = 500,
   parameter int SCORE_W  = 24
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [10:0]                   hcount_in,
   input  logic [10:0]                   vcount_in,
   input  logic                          hsync_in,
   input  logic                          hblnk_in,
   input  logic                          vsync_in,
   input  logic                          vblnk_in,
   input  logic [11:0]                   rgb_in,
   input  logic [11:0]                   hero_x_pos,
   input  logic [11:0]                   hero_y_pos,
   input  logic [COLS*ROWS*TYPE_W-1:0]   map,
   input  logic                          level_start,
   output logic [10:0]                   hcount_out,
   output logic [10:0]                   vcount_out,
   output logic                          hsync_out,
   output logic                          hblnk_out,
   output logic                          vsync_out,
   output logic                          vblnk_out,
   output logic [11:0]                   rgb_out,
   output logic [3:0]                    collision,
   output logic [SCORE_W-1:0]            score_out,
   output logic                          level_clear,
   output logic                          frame_done
);

   localparam int NT    = COLS * ROWS;
   localparam int IDX_W = $clog2(NT);
   localparam int COL_W = $clog2(COLS);
   localparam int ROW_W = $clog2(ROWS);
   localparam int OFF_W = $clog2(TILE);
   localparam int CNT_W = $clog2(NT + 1);

   localparam logic [TYPE_W-1:0] T_WALL = TYPE_W'(1);
   localparam logic [TYPE_W-1:0] T_COIN = TYPE_W'(2);
   localparam logic [TYPE_W-1:0] T_PWR  = TYPE_W'(3);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

   // ---------------------------------------------------------------- video
   logic [10:0]      hrel, vrel;
   logic             in_area;
   logic [10:0]      s1_hcount, s1_vcount;
   logic             s1_hsync, s1_hblnk, s1_vsync, s1_vblnk, s1_in_area;
   logic [11:0]      s1_rgb;
   logic [COL_W-1:0] s1_col;
   logic [ROW_W-1:0] s1_row;
   logic [OFF_W-1:0] s1_ox, s1_oy;
   logic [IDX_W-1:0] pix_idx;
   logic [TYPE_W-1:0] pix_type;
   logic             pix_inset;
   logic [11:0]      pix_rgb;
   logic [NT-1:0]    picked;

   // Map-relative pixel coordinates and map-area test.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      hrel    = hcount_in - 11'(X0);
      vrel    = vcount_in - 11'(Y0);
      in_area = (hcount_in >= 11'(X0)) && (hcount_in < 11'(X0 + COLS*TILE)) &&
                (vcount_in >= 11'(Y0)) && (vcount_in < 11'(Y0 + ROWS*TILE));
   end

   // Stage 1: delay timing and split position into tile column/row and offsets.
   // NOTE: clocked state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_hcount <= '0; s1_vcount <= '0;
         s1_hsync  <= 1'b0; s1_hblnk <= 1'b0; s1_vsync <= 1'b0; s1_vblnk <= 1'b0;
         s1_rgb    <= '0; s1_in_area <= 1'b0;
         s1_col    <= '0; s1_row <= '0; s1_ox <= '0; s1_oy <= '0;
      end else begin
         s1_hcount  <= hcount_in; s1_vcount <= vcount_in;
         s1_hsync   <= hsync_in;  s1_hblnk  <= hblnk_in;
         s1_vsync   <= vsync_in;  s1_vblnk  <= vblnk_in;
         s1_rgb     <= rgb_in;
         s1_in_area <= in_area;
         s1_col     <= in_area ? COL_W'(hrel / 11'(TILE)) : '0;
         s1_row     <= in_area ? ROW_W'(vrel / 11'(TILE)) : '0;
         s1_ox      <= in_area ? OFF_W'(hrel % 11'(TILE)) : '0;
         s1_oy      <= in_area ? OFF_W'(vrel % 11'(TILE)) : '0;
      end
   end

   // Tile lookup and colour selection for the stage-1 pixel.
   always_comb begin
      pix_idx   = IDX_W'(s1_col) + IDX_W'(s1_row) * IDX_W'(COLS);
      pix_type  = map[pix_idx*TYPE_W +: TYPE_W];
      pix_inset = (s1_ox >= OFF_W'(MARGIN)) && (s1_ox < OFF_W'(TILE - MARGIN)) &&
                  (s1_oy >= OFF_W'(MARGIN)) && (s1_oy < OFF_W'(TILE - MARGIN));
      pix_rgb   = s1_rgb;
      if (s1_in_area) begin
         if (pix_type == T_WALL)
            pix_rgb = 12'h630;
         else if (pix_type == T_COIN && pix_inset && !picked[pix_idx])
            pix_rgb = 12'hfff;
         else if (pix_type == T_PWR && pix_inset && !picked[pix_idx])
            pix_rgb = 12'h0ff;
      end
   end

   // Stage 2: register the delayed timing and the final pixel colour.
   always_ff @(posedge clk) begin
      if (rst) begin
         hcount_out <= '0; vcount_out <= '0;
         hsync_out  <= 1'b0; hblnk_out <= 1'b0; vsync_out <= 1'b0; vblnk_out <= 1'b0;
         rgb_out    <= '0;
      end else begin
         hcount_out <= s1_hcount; vcount_out <= s1_vcount;
         hsync_out  <= s1_hsync;  hblnk_out  <= s1_hblnk;
         vsync_out  <= s1_vsync;  vblnk_out  <= s1_vblnk;
         rgb_out    <= pix_rgb;
      end
   end

   // -------------------------------------------------------------- scanner
   state_t           state;
   logic             vsync_prev;
   logic [IDX_W-1:0] idx;
   logic [COL_W-1:0] scol;
   logic [13:0]      tx, ty;
   logic [3:0]       coll_acc;
   logic [CNT_W-1:0] remain_cnt;
   logic [SCORE_W-1:0] score_next;

   logic [13:0]      hx, hy, t14;
   logic [TYPE_W-1:0] scan_type;
   logic             x_ov, y_ov, item_ov, is_item;
   logic [3:0]       wall_hit;
   logic [SCORE_W:0] score_sum;

   // Overlap tests for the tile under the scanner; all arithmetic is additive.
   always_comb begin
      hx        = 14'(hero_x_pos);
      hy        = 14'(hero_y_pos);
      t14       = 14'(TILE);
      scan_type = map[idx*TYPE_W +: TYPE_W];
      x_ov      = (hx < tx + t14) && (hx + t14 > tx);
      y_ov      = (hy < ty + t14) && (hy + t14 > ty);
      wall_hit[0] = (hx < tx + t14 + 14'd1) && (hx + t14 > tx + 14'd1) && y_ov;
      wall_hit[1] = (hx + 14'd1 < tx + t14) && (hx + t14 + 14'd1 > tx) && y_ov;
      wall_hit[2] = (hy + 14'd1 < ty + t14) && (hy + t14 + 14'd1 > ty) && x_ov;
      wall_hit[3] = (hy < ty + t14 + 14'd1) && (hy + t14 > ty + 14'd1) && x_ov;
      item_ov   = (hx < tx + 14'(TILE - MARGIN)) && (hx + t14 > tx + 14'(MARGIN)) &&
                  (hy < ty + 14'(TILE - MARGIN)) && (hy + t14 > ty + 14'(MARGIN));
      is_item   = (scan_type == T_COIN || scan_type == T_PWR) && !picked[idx];
      score_sum = {1'b0, score_out} +
                  ((scan_type == T_PWR) ? (SCORE_W+1)'(PWR_PTS) : (SCORE_W+1)'(COIN_PTS));
      score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
   end

   // Previous vsync level for rising-edge detection.
   always_ff @(posedge clk) begin
      if (rst) vsync_prev <= 1'b0;
      else     vsync_prev <= vsync_in;
   end

   // Scanner FSM: one tile per cycle, results published in DONE.
   // NOTE: picked is a flop vector, not a RAM, so it can be cleared in one cycle by rst/level_start.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         idx         <= '0; scol <= '0; tx <= '0; ty <= '0;
         coll_acc    <= '0; remain_cnt <= '0;
         picked      <= '0;
         collision   <= '0; score_out <= '0; level_clear <= 1'b0; frame_done <= 1'b0;
      end else if (level_start) begin
         state      <= S_IDLE;
         picked     <= '0;
         collision  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (vsync_in && !vsync_prev) begin
                  state      <= S_SCAN;
                  idx        <= '0; scol <= '0;
                  tx         <= 14'(X0); ty <= 14'(Y0);
                  coll_acc   <= '0; remain_cnt <= '0;
               end
            end
            S_SCAN: begin
               if (scan_type == T_WALL) coll_acc <= coll_acc | wall_hit;
               if (is_item) begin
                  if (item_ov) begin
                     picked[idx] <= 1'b1;
                     score_out   <= score_next;
                  end else begin
                     remain_cnt  <= remain_cnt + 1'b1;
                  end
               end
               if (idx == IDX_W'(NT - 1)) begin
                  state <= S_DONE;
               end else begin
                  idx <= idx + 1'b1;
                  if (scol == COL_W'(COLS - 1)) begin
                     scol <= '0;
                     tx   <= 14'(X0);
                     ty   <= ty + t14;
                  end else begin
                     scol <= scol + 1'b1;
                     tx   <= tx + t14;
                  end
               end
            end
            S_DONE: begin
               collision   <= coll_acc;
               level_clear <= (remain_cnt == '0);
               frame_done  <= 1'b1;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
